enc_capture_disp: RTL and testbench
===================================

// Module: enc_capture_disp
// PURPOSE
//  Downstream stage of the 16-to-4 priority encoder. It takes the 4-bit code and an any-input-valid flag,
//  qualifies the code as stable over several clocks, and latches it.
//  It holds the latched value on a hex 7-seg digit for a minimum time and counts captures (mod 16) on a second digit.
//  Sits between the encoder and the board's seven-segment/LED pins.
// PARAMETERS
//  STABLE_CYCLES  4  consecutive identical valid samples required to capture (legal >= 2)
//  HOLD_CYCLES    8  cycles input is ignored after a capture (legal >= 1; board build uses ~50_000_000)
// PORTS
//  clk         in   1  system clock, all state on rising edge
//  rst         in   1  synchronous, active-high reset
//  code_in     in   4  encoder output y
//  code_valid  in   1  encoder enable AND any bit of its 16-bit input set
//  seg_code    out  7  gfedcba pattern of last captured code; blank until first capture
//  seg_cnt     out  7  gfedcba pattern of capture count (hex, mod 16)
//  cap_pulse   out  1  one-cycle pulse in the cycle after a capture
//  led_valid   out  1  1 once at least one code has been captured
//  busy        out  1  1 in HOLD or WAIT_REL
// BEHAVIOUR
//  Reset (rst=1 at edge): state=IDLE; code_q=0; cnt_q=0; have_q=0; cap_pulse=0; busy=0.
//   seg_code=7'h00 (blank); seg_cnt=7'h3F ("0"). Reset wins over every other event.
//  All outputs are registered or decoded from registers only; no combinational path from inputs.
//  FSM, 4 states:
//   IDLE: code_valid=1 -> cand<=code_in, stab<=1, go QUAL. Otherwise stay.
//   QUAL: code_valid=0 -> IDLE (no capture).
//     code_in!=cand -> cand<=code_in, stab<=1.
//     code_in==cand and stab==STABLE_CYCLES-1 -> capture, go HOLD, hold<=0.
//     Otherwise stab<=stab+1.
//   capture: code_q<=cand; cnt_q<=cnt_q+1 (4-bit, wraps 15->0); have_q<=1; cap_pulse<=1 for one cycle.
//   HOLD: code_in/code_valid ignored; hold<=hold+1.
//     When hold==HOLD_CYCLES-1: go WAIT_REL if code_valid=1, else go IDLE.
//   WAIT_REL: stay while code_valid=1; code_valid=0 -> IDLE. A held key captures exactly once.
//  Latency: valid sampled at edge k with a constant code -> capture at edge k+STABLE_CYCLES-1.
//   cap_pulse and the new seg values are visible after that edge.
//  Counter widths: stab and hold sized with $clog2(param+1); no overflow, since they reset on every state entry.
//  Code change in the same cycle as the would-be capture edge: no capture, the count restarts at 1.
//  Code 0 is legal: valid with code 0 (encoder x[0] only) captures "0".
// CONFIGURATION
//  ENC_DISP_ACTIVE_LOW_EN defined: seg_code and seg_cnt are bitwise inverted (common-anode boards).
//   Blank becomes 7'h7F, "0" becomes 7'h40. led_valid and busy are unchanged.
//  Not defined: segments are active-high, as specified above.
// STRUCTURE
//  Package enc_disp_pkg holds:
//   - state encodings: IDLE=2'd0, QUAL=2'd1, HOLD=2'd2, WAIT_REL=2'd3
//   - the 16-entry hex-to-gfedcba constant table
//   - the SEG_BLANK constant
//  Sub-module hex7seg (4-bit in, 7-bit out, pure lookup) is instantiated twice (code digit, count digit).
//  The FSM and counters live in this module.
// TESTING (STABLE_CYCLES=4, HOLD_CYCLES=8, active-high)
//  1. Assert rst 2 cycles -> seg_code=7'h00, seg_cnt=7'h3F, led_valid=0, busy=0, cap_pulse=0.
//  2. Valid, code 9 for 20 cycles from edge k -> single capture at k+3: seg_code=7'h6F, seg_cnt=7'h06,
//     one cap_pulse, busy 1 until release, then IDLE.
//  3. Valid with code sequence 3,3,5,5,5,5 -> no capture on the 3s; capture of 5 at the 4th 5; seg_code=7'h6D.
//  4. Valid for 3 cycles, then drop -> no capture; cnt unchanged; state returns to IDLE.
//  5. 16 separate press/release captures of code F -> seg_cnt wraps to 7'h3F (0); last seg_code=7'h71.
//  6. rst asserted mid-HOLD -> all reset values next cycle.
//     Input held valid through reset -> fresh capture STABLE_CYCLES cycles after rst drops.
//  7. Rerun case 2 with ENC_DISP_ACTIVE_LOW_EN -> seg_code=7'h10, seg_cnt=7'h79.

Source files
------------

// File: rtl/enc_disp_pkg.sv
// rtl/enc_disp_pkg.sv - shared state encodings and segment table for enc_capture_disp
package enc_disp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_QUAL     = 2'd1,
    ST_HOLD     = 2'd2,
    ST_WAIT_REL = 2'd3
  } state_e;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  // gfedcba patterns, entry 15 first so that HEX_SEG_TABLE[n] is digit n
  localparam logic [15:0][6:0] HEX_SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39,
    7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66,
    7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/hex7seg.sv
// rtl/hex7seg.sv - 4-bit hex digit to active-high gfedcba segment lookup
module hex7seg
  import enc_disp_pkg::*;
(
  input  logic [3:0] hex_in,
  output logic [6:0] seg_out
);

  assign seg_out = HEX_SEG_TABLE[hex_in];

endmodule

// File: rtl/enc_capture_disp.sv
// rtl/enc_capture_disp.sv - qualify, latch and display encoder code plus capture count
// Optional ENC_DISP_ACTIVE_LOW_EN inverts both segment outputs for common-anode boards.
module enc_capture_disp
  import enc_disp_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int HOLD_CYCLES   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] code_in,
  input  logic       code_valid,
  output logic [6:0] seg_code,
  output logic [6:0] seg_cnt,
  output logic       cap_pulse,
  output logic       led_valid,
  output logic       busy
);

  localparam int SW = $clog2(STABLE_CYCLES + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [SW-1:0] STAB_ONE  = SW'(1);
  localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_ONE  = HW'(1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  state_e        state_q, state_d;
  logic [3:0]    cand_q,  cand_d;
  logic [SW-1:0] stab_q,  stab_d;
  logic [HW-1:0] hold_q,  hold_d;
  logic [3:0]    code_q,  code_d;
  logic [3:0]    cnt_q,   cnt_d;
  logic          have_q,  have_d;
  logic          cap_q,   cap_d;
  logic          capture;

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    stab_d  = stab_q;
    hold_d  = hold_q;
    capture = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (code_valid) begin
          cand_d  = code_in;
          stab_d  = STAB_ONE;
          state_d = ST_QUAL;
        end
      end
      ST_QUAL: begin
        if (!code_valid) begin
          state_d = ST_IDLE;
        end else if (code_in != cand_q) begin
          // a change on the would-be capture edge also lands here: restart at 1
          cand_d = code_in;
          stab_d = STAB_ONE;
        end else if (stab_q == STAB_LAST) begin
          capture = 1'b1;
          hold_d  = '0;
          state_d = ST_HOLD;
        end else begin
          stab_d = stab_q + STAB_ONE;
        end
      end
      ST_HOLD: begin
        if (hold_q == HOLD_LAST) begin
          state_d = code_valid ? ST_WAIT_REL : ST_IDLE;
        end else begin
          hold_d = hold_q + HOLD_ONE;
        end
      end
      ST_WAIT_REL: begin
        if (!code_valid) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    code_d = code_q;
    cnt_d  = cnt_q;
    have_d = have_q;
    cap_d  = 1'b0;
    if (capture) begin
      code_d = cand_q;
      cnt_d  = cnt_q + 4'd1;
      have_d = 1'b1;
      cap_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cand_q  <= '0;
      stab_q  <= '0;
      hold_q  <= '0;
      code_q  <= '0;
      cnt_q   <= '0;
      have_q  <= 1'b0;
      cap_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      stab_q  <= stab_d;
      hold_q  <= hold_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
      have_q  <= have_d;
      cap_q   <= cap_d;
    end
  end

  logic [6:0] code_pat;
  logic [6:0] cnt_pat;
  logic [6:0] code_seg_hi;

  hex7seg u_code_seg (
    .hex_in  (code_q),
    .seg_out (code_pat)
  );

  hex7seg u_cnt_seg (
    .hex_in  (cnt_q),
    .seg_out (cnt_pat)
  );

  assign code_seg_hi = have_q ? code_pat : SEG_BLANK;

`ifdef ENC_DISP_ACTIVE_LOW_EN
  assign seg_code = ~code_seg_hi;
  assign seg_cnt  = ~cnt_pat;
`else
  assign seg_code = code_seg_hi;
  assign seg_cnt  = cnt_pat;
`endif

  assign cap_pulse = cap_q;
  assign led_valid = have_q;
  assign busy      = (state_q == ST_HOLD) || (state_q == ST_WAIT_REL);

endmodule

// File: tb/tb_enc_capture_disp.sv
// tb/tb_enc_capture_disp.sv - self-checking bench for enc_capture_disp
module tb_enc_capture_disp;

  localparam int STABLE = 4;
  localparam int HOLD   = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] code_in = 4'h0;
  logic       code_valid = 1'b0;
  logic [6:0] seg_code;
  logic [6:0] seg_cnt;
  logic       cap_pulse;
  logic       led_valid;
  logic       busy;

  int checks   = 0;
  int failures = 0;
  int dut_pulses = 0;

  enc_capture_disp #(.STABLE_CYCLES(STABLE), .HOLD_CYCLES(HOLD)) dut (
    .clk        (clk),
    .rst        (rst),
    .code_in    (code_in),
    .code_valid (code_valid),
    .seg_code   (seg_code),
    .seg_cnt    (seg_cnt),
    .cap_pulse  (cap_pulse),
    .led_valid  (led_valid),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  logic [6:0] seg_ref [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  function automatic logic [6:0] pol(input logic [6:0] v);
`ifdef ENC_DISP_ACTIVE_LOW_EN
    return ~v;
`else
    return v;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: counts consecutive identical valid samples, a lockout
  // timer after each capture, and a release flag for held keys.
  bit         m_ready = 0;
  int         m_run, m_ignore;
  bit         m_rel, m_have, m_pulse;
  logic [3:0] m_last, m_code, m_cnt;

  always @(posedge clk) begin
    if (rst) begin
      m_ready = 1; m_run = 0; m_ignore = 0; m_rel = 0; m_have = 0; m_pulse = 0;
      m_last = 0; m_code = 0; m_cnt = 0;
    end else if (m_ready) begin
      m_pulse = 0;
      if (m_ignore > 0) begin
        m_ignore--;
        if (m_ignore == 0) m_rel = code_valid;
      end else if (m_rel) begin
        if (!code_valid) m_rel = 0;
      end else if (!code_valid) begin
        m_run = 0;
      end else if (m_run > 0 && code_in == m_last) begin
        m_run++;
        if (m_run == STABLE) begin
          m_code = m_last; m_cnt = m_cnt + 4'd1; m_have = 1; m_pulse = 1;
          m_ignore = HOLD; m_run = 0;
        end
      end else begin
        m_run = 1; m_last = code_in;
      end
    end
  end

  always @(negedge clk) begin
    if (m_ready) begin
      check("mdl_seg_code", seg_code, m_have ? pol(seg_ref[m_code]) : pol(7'h00));
      check("mdl_seg_cnt", seg_cnt, pol(seg_ref[m_cnt]));
      check("mdl_cap_pulse", cap_pulse, m_pulse);
      check("mdl_led_valid", led_valid, m_have);
      check("mdl_busy", busy, (m_ignore > 0) || m_rel);
      if (cap_pulse) dut_pulses++;
    end
  end

  task automatic cyc(input logic v, input logic [3:0] c);
    code_valid = v;
    code_in    = c;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 4'h0);
  endtask

  int p0;

  initial begin
    // 1: reset
    rst = 1'b1;
    cyc(1'b0, 4'h0);
    cyc(1'b0, 4'h0);
    check("rst_seg_code", seg_code, pol(7'h00));
    check("rst_seg_cnt", seg_cnt, pol(7'h3F));
    check("rst_led_valid", led_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_cap_pulse", cap_pulse, 1'b0);
    rst = 1'b0;

    // 2: held code 9 captures once at k+3
    p0 = dut_pulses;
    for (int i = 0; i < 3; i++) cyc(1'b1, 4'h9);
    check("c2_no_early_cap", cap_pulse, 1'b0);
    cyc(1'b1, 4'h9);
    check("c2_cap_pulse", cap_pulse, 1'b1);
    check("c2_seg_code", seg_code, pol(7'h6F));
    check("c2_seg_cnt", seg_cnt, pol(7'h06));
    check("c2_busy", busy, 1'b1);
    for (int i = 0; i < 16; i++) cyc(1'b1, 4'h9);
    check("c2_busy_held", busy, 1'b1);
    cyc(1'b0, 4'h0);
    check("c2_busy_released", busy, 1'b0);
    #4;
    check("c2_pulse_count", dut_pulses - p0, 1);

    // 3: 3,3,5,5,5,5
    cyc(1'b1, 4'h3); cyc(1'b1, 4'h3);
    for (int i = 0; i < 3; i++) cyc(1'b1, 4'h5);
    check("c3_no_cap", cap_pulse, 1'b0);
    cyc(1'b1, 4'h5);
    check("c3_cap", cap_pulse, 1'b1);
    check("c3_seg_code", seg_code, pol(7'h6D));
    idle(9);
    check("c3_idle", busy, 1'b0);

    // change on the would-be capture edge: 4,4,4,6 then 6,6,6
    for (int i = 0; i < 3; i++) cyc(1'b1, 4'h4);
    cyc(1'b1, 4'h6);
    check("chg_no_cap", cap_pulse, 1'b0);
    cyc(1'b1, 4'h6); cyc(1'b1, 4'h6);
    check("chg_no_cap2", cap_pulse, 1'b0);
    cyc(1'b1, 4'h6);
    check("chg_cap", cap_pulse, 1'b1);
    check("chg_seg_code", seg_code, pol(7'h7D));
    idle(9);

    // 4: valid for 3 then drop
    p0 = dut_pulses;
    for (int i = 0; i < 3; i++) cyc(1'b1, 4'h7);
    idle(3);
    #4;
    check("c4_no_cap", dut_pulses - p0, 0);
    check("c4_seg_cnt", seg_cnt, pol(7'h4F));
    check("c4_busy", busy, 1'b0);

    // 5: 16 captures of F from a fresh count
    rst = 1'b1; cyc(1'b0, 4'h0); cyc(1'b0, 4'h0); rst = 1'b0;
    for (int n = 0; n < 16; n++) begin
      for (int i = 0; i < 4; i++) cyc(1'b1, 4'hF);
      idle(9);
      if (n == 14) check("c5_cnt_15", seg_cnt, pol(7'h71));
    end
    check("c5_cnt_wrap", seg_cnt, pol(7'h3F));
    check("c5_seg_code", seg_code, pol(7'h71));
    check("c5_led_valid", led_valid, 1'b1);

    // 6: reset mid-HOLD with input held valid
    for (int i = 0; i < 7; i++) cyc(1'b1, 4'h2);
    rst = 1'b1;
    cyc(1'b1, 4'h2);
    check("c6_seg_code", seg_code, pol(7'h00));
    check("c6_seg_cnt", seg_cnt, pol(7'h3F));
    check("c6_busy", busy, 1'b0);
    check("c6_led_valid", led_valid, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) cyc(1'b1, 4'h2);
    check("c6_no_early_cap", cap_pulse, 1'b0);
    cyc(1'b1, 4'h2);
    check("c6_cap", cap_pulse, 1'b1);
    check("c6_seg_code_2", seg_code, pol(7'h5B));
    check("c6_seg_cnt_1", seg_cnt, pol(7'h06));
    idle(9);

    // code 0 is a legal capture
    for (int i = 0; i < 4; i++) cyc(1'b1, 4'h0);
    check("z_seg_code", seg_code, pol(7'h3F));
    check("z_seg_cnt", seg_cnt, pol(7'h5B));
    idle(9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
